fetch_sequencer: RTL and testbench

//  PC/nPC sequencer for the fetch stage; consumes the condition handler's taken (TA_Ctrl) and link (BL_cond) results.

---
 rtl/fetch_sequencer_pkg.sv | 13 +
 rtl/fetch_sequencer_if.sv | 11 +
 rtl/fs_pc_reg.sv | 42 ++++
 rtl/fetch_sequencer.sv | 110 +++++++++++
 tb/tb_fetch_sequencer.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch-stage PC/nPC sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fs_state_e;

    localparam int unsigned INSTR_BYTES = 4;
    localparam int unsigned LINK_OFFSET = 8;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/ack handshake between the fetch sequencer and memory.
interface fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;

    modport master (output req, output addr, input ack);
    modport slave  (input req, input addr, output ack);
endinterface

// File: rtl/fs_pc_reg.sv
// PC/nPC pair plus the pending redirect target held while an old fetch drains.
module fs_pc_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              advance,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic              pend_we,
    input  logic [ADDR_W-1:0] pend_d,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] npc,
    output logic [ADDR_W-1:0] pend
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(INSTR_BYTES);

    // load wins over advance: a redirect always replaces the sequential path
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc   <= RESET_PC;
            npc  <= RESET_PC + STEP;
            pend <= '0;
        end else begin
            if (load) begin
                pc  <= load_addr;
                npc <= load_addr + STEP;
            end else if (advance) begin
                pc  <= npc;
                npc <= npc + STEP;
            end
            if (pend_we) begin
                pend <= pend_d;
            end
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC/nPC sequencer: drives imem handshake, redirects on taken branches, writes BL link.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    fetch_sequencer_if.master    imem,
    input  logic                 stall_in,
    input  logic                 ex_valid_in,
    input  logic                 ta_ctrl_in,
    input  logic                 bl_cond_in,
    input  logic [ADDR_W-1:0]    target_addr_in,
    input  logic [ADDR_W-1:0]    ex_pc_in,
    output logic                 if_valid_out,
    output logic [ADDR_W-1:0]    pc_out,
    output logic [ADDR_W-1:0]    npc_out,
    output logic                 link_we_out,
    output logic [ADDR_W-1:0]    link_data_out
);

    fs_state_e         state_q, state_d;
    logic              redirect;
    logic              link_fire;
    logic              pc_advance;
    logic              pc_load;
    logic [ADDR_W-1:0] load_addr;
    logic              pend_we;
    logic [ADDR_W-1:0] pc_q, npc_q, pend_q;

    fs_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .advance   (pc_advance),
        .load      (pc_load),
        .load_addr (load_addr),
        .pend_we   (pend_we),
        .pend_d    (target_addr_in),
        .pc        (pc_q),
        .npc       (npc_q),
        .pend      (pend_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= BOOT;
            link_we_out   <= 1'b0;
            link_data_out <= '0;
        end else begin
            state_q     <= state_d;
            link_we_out <= link_fire;
            if (link_fire) begin
                link_data_out <= ex_pc_in + ADDR_W'(LINK_OFFSET);
            end
        end
    end

    // Redirect is only honoured in RUN; in DRAIN the outstanding fetch must finish first.
    always_comb begin
        state_d      = state_q;
        redirect     = 1'b0;
        link_fire    = 1'b0;
        pc_advance   = 1'b0;
        pc_load      = 1'b0;
        load_addr    = target_addr_in;
        pend_we      = 1'b0;
        if_valid_out = 1'b0;
        unique case (state_q)
            BOOT: begin
                state_d = RUN;
            end
            RUN: begin
                redirect  = ex_valid_in & ta_ctrl_in;
                link_fire = redirect & bl_cond_in;
                if (redirect) begin
                    if (imem.ack) begin
                        pc_load = 1'b1;
                    end else begin
                        pend_we = 1'b1;
                        state_d = DRAIN;
                    end
                end else if (imem.ack && !stall_in) begin
                    if_valid_out = 1'b1;
                    pc_advance   = 1'b1;
                end
            end
            DRAIN: begin
                if (imem.ack) begin
                    pc_load   = 1'b1;
                    load_addr = pend_q;
                    state_d   = RUN;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    assign imem.req  = (state_q != BOOT);
    assign imem.addr = pc_q;
    assign pc_out    = pc_q;
    assign npc_out   = npc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed scenarios then randomized traffic vs. a behavioural model.
module tb_fetch_sequencer;

    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          stall_in, ex_valid_in, ta_ctrl_in, bl_cond_in;
    logic [AW-1:0] target_addr_in, ex_pc_in;
    logic          if_valid_out, link_we_out;
    logic [AW-1:0] pc_out, npc_out, link_data_out;

    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(AW)) imem_if ();

    fetch_sequencer #(.ADDR_W(AW), .RESET_PC('0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem           (imem_if.master),
        .stall_in       (stall_in),
        .ex_valid_in    (ex_valid_in),
        .ta_ctrl_in     (ta_ctrl_in),
        .bl_cond_in     (bl_cond_in),
        .target_addr_in (target_addr_in),
        .ex_pc_in       (ex_pc_in),
        .if_valid_out   (if_valid_out),
        .pc_out         (pc_out),
        .npc_out        (npc_out),
        .link_we_out    (link_we_out),
        .link_data_out  (link_data_out)
    );

    typedef struct {
        bit        req;
        bit [31:0] addr;
        bit        ifv;
        bit [31:0] pc;
        bit [31:0] npc;
        bit        lwe;
        bit [31:0] ldata;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    // Architectural model: the fetch pointer pair, a "waiting for old fetch" flag and its target.
    bit        m_booting;
    bit        m_waiting;
    bit [31:0] m_pc, m_npc, m_pend, m_ldata;
    bit        m_lwe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit rst, input bit st, input bit exv, input bit ta, input bit bl,
                       input bit [31:0] tgt, input bit [31:0] epc, input bit ack);
        exp_t e;
        bit   taken;
        @(negedge clk);
        reset_n        = rst;
        stall_in       = st;
        ex_valid_in    = exv;
        ta_ctrl_in     = ta;
        bl_cond_in     = bl;
        target_addr_in = tgt;
        ex_pc_in       = epc;
        imem_if.ack    = ack;
        #1;
        if (!rst) begin
            m_booting = 1'b1;
            m_waiting = 1'b0;
            m_pc      = 32'h0;
            m_npc     = 32'h4;
            m_lwe     = 1'b0;
            m_ldata   = 32'h0;
        end
        taken   = !m_booting && !m_waiting && exv && ta;
        e.req   = !m_booting;
        e.addr  = m_pc;
        e.ifv   = !m_booting && !m_waiting && ack && !taken && !st;
        e.pc    = m_pc;
        e.npc   = m_npc;
        e.lwe   = m_lwe;
        e.ldata = m_ldata;
        sb.push_back(e);
        if (rst) begin
            m_lwe = taken && bl;
            if (m_lwe) m_ldata = epc + 32'd8;
            if (m_booting) begin
                m_booting = 1'b0;
            end else if (m_waiting) begin
                if (ack) begin
                    m_pc      = m_pend;
                    m_npc     = m_pend + 32'd4;
                    m_waiting = 1'b0;
                end
            end else if (taken) begin
                if (ack) begin
                    m_pc  = tgt;
                    m_npc = tgt + 32'd4;
                end else begin
                    m_pend    = tgt;
                    m_waiting = 1'b1;
                end
            end else if (ack && !st) begin
                m_pc  = m_npc;
                m_npc = m_npc + 32'd4;
            end
        end
    endtask

    // Monitor: compares every DUT output against the queued expectation, well after the edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("req",       {31'd0, imem_if.req},  {31'd0, e.req});
                check("addr",      imem_if.addr,          e.addr);
                check("if_valid",  {31'd0, if_valid_out}, {31'd0, e.ifv});
                check("pc",        pc_out,                e.pc);
                check("npc",       npc_out,               e.npc);
                check("link_we",   {31'd0, link_we_out},  {31'd0, e.lwe});
                check("link_data", link_data_out,         e.ldata);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : driver
        bit [31:0] tgt;
        reset_n = 1'b0; stall_in = 1'b0; ex_valid_in = 1'b0; ta_ctrl_in = 1'b0;
        bl_cond_in = 1'b0; target_addr_in = '0; ex_pc_in = '0; imem_if.ack = 1'b0;

        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        check("rst_req", {31'd0, imem_if.req}, 32'd0);
        check("rst_pc",  pc_out,  32'h0);
        check("rst_npc", npc_out, 32'h4);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("boot_req", {31'd0, imem_if.req}, 32'd0);

        // sequential fetch
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("seq_addr0", imem_if.addr, 32'h0);
        check("seq_ifv0",  {31'd0, if_valid_out}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("seq_addr4", imem_if.addr, 32'h4);
        cyc(1, 1, 0, 0, 0, 0, 0, 1);
        check("stall_addr8", imem_if.addr, 32'h8);
        check("stall_ifv",   {31'd0, if_valid_out}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("refetch_addr8", imem_if.addr, 32'h8);
        check("refetch_ifv",   {31'd0, if_valid_out}, 32'd1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("seq_addr12", imem_if.addr, 32'hC);

        // taken branch with ack at pc=0x10
        cyc(1, 0, 1, 1, 0, 32'h100, 32'h0C, 1);
        check("taken_addr", imem_if.addr, 32'h10);
        check("taken_ifv",  {31'd0, if_valid_out}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("taken_pc",  pc_out,  32'h100);
        check("taken_npc", npc_out, 32'h104);

        // taken branch, ack arrives later; redirect inputs during drain are ignored
        cyc(1, 0, 1, 1, 0, 32'h200, 32'hF0, 0);
        cyc(1, 0, 1, 1, 1, 32'h999, 32'h80, 0);
        check("drain_addr1", imem_if.addr, 32'h100);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("drain_addr2", imem_if.addr, 32'h100);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("drain_ack_addr", imem_if.addr, 32'h100);
        check("drain_squash",   {31'd0, if_valid_out}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("drain_target", imem_if.addr, 32'h200);
        check("drain_no_link", {31'd0, link_we_out}, 32'd0);

        // branch-and-link
        cyc(1, 0, 1, 1, 1, 32'h300, 32'h40, 1);
        cyc(1, 0, 1, 0, 1, 32'h700, 32'h60, 0);
        check("bl_we",   {31'd0, link_we_out}, 32'd1);
        check("bl_data", link_data_out, 32'h48);
        check("bl_pc",   pc_out, 32'h300);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("bl_no_ta_we",  {31'd0, link_we_out}, 32'd0);
        check("bl_data_hold", link_data_out, 32'h48);

        // wrap at top of address space
        cyc(1, 0, 1, 1, 0, 32'hFFFF_FFFC, 32'h0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("wrap_pc",  pc_out,  32'hFFFF_FFFC);
        check("wrap_npc", npc_out, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        check("wrap_pc0", pc_out, 32'h0);

        // reset in the middle of a drain discards the pending target
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 1, 1, 0, 32'h500, 32'h0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
        check("mid_rst_pc",  pc_out, 32'h0);
        check("mid_rst_npc", npc_out, 32'h4);
        check("mid_rst_req", {31'd0, imem_if.req}, 32'd0);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 0, 0, 1);
        check("post_rst_addr", imem_if.addr, 32'h0);
        check("post_rst_ifv",  {31'd0, if_valid_out}, 32'd1);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFF_FFFC);
            cyc($urandom_range(0, 199) != 0,
                $urandom_range(0, 3) == 0,
                $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 1) == 1,
                tgt,
                $urandom,
                $urandom_range(0, 2) != 0);
        end

        @(negedge clk);
        #5;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
